ysyx_22040365_ctrl: RTL and testbench

YSYX_22040365_CTRL -- requirements
Module: ysyx_22040365_ctrl

---
 rtl/ysyx_22040365_ctrl.sv | 129 ++++++++++++
 tb/tb_ysyx_22040365_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040365_ctrl.sv
// Multi-cycle instruction control FSM: IDLE -> FETCH -> EXEC -> WB, with terminal HALT (ebreak) and ERR (fetch timeout).
// Latency: ack cycle + 2 per instruction (EXEC, WB); same-cycle ack retires one instruction every 3 cycles.
// Backpressure: FETCH holds ifu_req/ifu_addr stable until ifu_ack; TIMEOUT cycles without ack end in ERR.
module ysyx_22040365_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        ifu_req,
    output logic [63:0] ifu_addr,
    input  logic        ifu_ack,
    input  logic [31:0] ifu_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        wb_en,
    output logic [63:0] pc,
    output logic        halt,
    output logic        err,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret
);

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam int          WW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] wait_cnt;
    logic          timeout_hit;
    logic          is_ebreak;

    // The no-ack cycle that would bring the count to TIMEOUT is the one that errors out.
    assign timeout_hit = (wait_cnt == WW'(TIMEOUT - 1));
    assign is_ebreak   = (inst == EBREAK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: begin
                if (ifu_ack) begin
                    state_nxt = S_EXEC;
                end else if (timeout_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_EXEC:  state_nxt = S_WB;
            S_WB:    state_nxt = is_ebreak ? S_HALT : S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ifu_req    = 1'b0;
        inst_valid = 1'b0;
        wb_en      = 1'b0;
        halt       = 1'b0;
        err        = 1'b0;
        case (state)
            S_FETCH: ifu_req = 1'b1;
            S_EXEC:  inst_valid = 1'b1;
            S_WB: begin
                inst_valid = 1'b1;
                wb_en      = !is_ebreak;
            end
            S_HALT:  halt = 1'b1;
            S_ERR:   err = 1'b1;
            default: ;
        endcase
    end

    assign ifu_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RESET_PC;
            inst      <= 32'h0;
            wait_cnt  <= '0;
            cycle_cnt <= 64'h0;
            instret   <= 64'h0;
        end else begin
            if (state == S_FETCH) begin
                if (ifu_ack) begin
                    inst     <= ifu_rdata;
                    wait_cnt <= '0;
                end else if (!timeout_hit) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end else begin
                    wait_cnt <= '0;
                end
            end else begin
                wait_cnt <= '0;
            end

            if (state == S_FETCH || state == S_EXEC || state == S_WB) begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end

            if (state == S_WB) begin
                instret <= instret + 64'd1;
                if (!is_ebreak) begin
                    pc <= pc + 64'd4;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040365_ctrl.sv
// Directed bench for ysyx_22040365_ctrl: fetch addresses go through a scoreboard queue, all other results are checked inline.
module tb_ysyx_22040365_ctrl;

    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [63:0] RPC    = 64'h0000_0000_8000_0000;
    localparam logic [63:0] WPC    = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ifu_ack;
    logic [31:0] ifu_rdata;

    logic        ifu_req, inst_valid, wb_en, halt, err;
    logic [63:0] ifu_addr, pc, cycle_cnt, instret;
    logic [31:0] inst;

    logic        w_ifu_req, w_inst_valid, w_wb_en, w_halt, w_err;
    logic [63:0] w_ifu_addr, w_pc, w_cycle_cnt, w_instret;
    logic [31:0] w_inst;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] addr_q[$];

    always #5 clk = ~clk;

    ysyx_22040365_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_ack(ifu_ack), .ifu_rdata(ifu_rdata),
        .inst(inst), .inst_valid(inst_valid), .wb_en(wb_en), .pc(pc),
        .halt(halt), .err(err), .cycle_cnt(cycle_cnt), .instret(instret)
    );

    ysyx_22040365_ctrl #(.RESET_PC(WPC)) u_wrap (
        .clk(clk), .rst(rst), .start(start),
        .ifu_req(w_ifu_req), .ifu_addr(w_ifu_addr), .ifu_ack(ifu_ack), .ifu_rdata(ifu_rdata),
        .inst(w_inst), .inst_valid(w_inst_valid), .wb_en(w_wb_en), .pc(w_pc),
        .halt(w_halt), .err(w_err), .cycle_cnt(w_cycle_cnt), .instret(w_instret)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Score any accepted fetch in the current cycle, then advance to just after the next rising edge.
    task automatic tick();
        if (ifu_req && ifu_ack) begin
            chk("fetch_expected", 64'(addr_q.size() != 0), 64'd1);
            if (addr_q.size() != 0) chk("fetch_addr", ifu_addr, addr_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        ifu_ack   = 1'b0;
        ifu_rdata = 32'h0;
        tick();
        tick();

        // Reset values on both instances
        chk("rst_pc", pc, RPC);
        chk("rst_ifu_addr", ifu_addr, RPC);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_ifu_req", 64'(ifu_req), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_wb_en", 64'(wb_en), 64'd0);
        chk("rst_halt", 64'(halt), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_cycle_cnt", cycle_cnt, 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("wrap_rst_pc", w_pc, WPC);
        chk("wrap_rst_ifu_addr", w_ifu_addr, WPC);
        chk("wrap_rst_outs", {w_inst, 27'd0, w_ifu_req, w_inst_valid, w_wb_en, w_halt, w_err}, 64'd0);
        chk("wrap_rst_cnts", w_cycle_cnt | w_instret, 64'd0);

        // Stays in IDLE after reset release; spurious ack ignored there
        rst = 1'b1;
        tick();
        ifu_ack   = 1'b1;
        ifu_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        chk("idle_ifu_req", 64'(ifu_req), 64'd0);
        chk("idle_inst", 64'(inst), 64'd0);
        chk("idle_cycle_cnt", cycle_cnt, 64'd0);

        // Back-to-back addi x3 with ack tied high
        ifu_rdata = ADDI;
        addr_q.push_back(RPC);
        addr_q.push_back(RPC + 64'd4);
        addr_q.push_back(RPC + 64'd8);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk("stream_ifu_req", 64'(ifu_req), 64'(i % 3 == 0));
            chk("stream_inst_valid", 64'(inst_valid), 64'(i % 3 != 0));
            chk("stream_wb_en", 64'(wb_en), 64'(i % 3 == 2));
            if (i == 3) chk("wrap_ifu_addr", w_ifu_addr, 64'd0);
            tick();
        end
        ifu_ack = 1'b0;
        chk("stream_instret", instret, 64'd3);
        chk("stream_cycle_cnt", cycle_cnt, 64'd9);
        chk("stream_next_addr", ifu_addr, RPC + 64'd12);
        chk("wrap_instret", w_instret, 64'd3);

        // Asynchronous reset mid-FETCH: takes effect with no clock edge
        chk("prefetch_ifu_req", 64'(ifu_req), 64'd1);
        rst = 1'b0;
        #2;
        chk("arst_fetch_pc", pc, RPC);
        chk("arst_fetch_ifu_req", 64'(ifu_req), 64'd0);
        chk("arst_fetch_cnts", cycle_cnt | instret, 64'd0);
        chk("arst_fetch_inst", 64'(inst), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("post_arst_idle", 64'(ifu_req), 64'd0);

        // addi then ebreak; spurious acks in EXEC/WB/HALT
        addr_q.push_back(RPC);
        ifu_ack   = 1'b1;
        ifu_rdata = ADDI;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        ifu_rdata = 32'hFFFF_FFFF;
        chk("exec_inst", 64'(inst), 64'(ADDI));
        chk("exec_wb_en", 64'(wb_en), 64'd0);
        tick();
        chk("wb_inst", 64'(inst), 64'(ADDI));
        chk("wb_wb_en", 64'(wb_en), 64'd1);
        tick();
        ifu_rdata = EBREAK;
        addr_q.push_back(RPC + 64'd4);
        tick();
        tick();
        chk("ebreak_wb_en", 64'(wb_en), 64'd0);
        chk("ebreak_inst_valid", 64'(inst_valid), 64'd1);
        ifu_rdata = 32'hFFFF_FFFF;
        start     = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("halt_halt", 64'(halt), 64'd1);
            chk("halt_ifu_req", 64'(ifu_req), 64'd0);
            chk("halt_inst_valid", 64'(inst_valid), 64'd0);
            tick();
        end
        chk("halt_pc", pc, RPC + 64'd4);
        chk("halt_instret", instret, 64'd2);
        chk("halt_cycle_cnt", cycle_cnt, 64'd6);
        chk("halt_inst", 64'(inst), 64'(EBREAK));
        start   = 1'b0;
        ifu_ack = 1'b0;
        do_reset();

        // Asynchronous reset mid-WB: no retirement
        addr_q.push_back(RPC);
        ifu_ack   = 1'b1;
        ifu_rdata = ADDI;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        ifu_ack = 1'b0;
        tick();
        chk("pre_arst_wb_en", 64'(wb_en), 64'd1);
        rst = 1'b0;
        #2;
        chk("arst_wb_wb_en", 64'(wb_en), 64'd0);
        chk("arst_wb_inst_valid", 64'(inst_valid), 64'd0);
        chk("arst_wb_instret", instret, 64'd0);
        chk("arst_wb_pc", pc, RPC);
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("post_arst_wb_idle", 64'(ifu_req), 64'd0);
        chk("post_arst_wb_instret", instret, 64'd0);

        // Ack withheld for the full timeout window
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 254; i++) begin
            chk("wait_ifu_req", 64'(ifu_req), 64'd1);
            tick();
        end
        chk("wait_err_pre", 64'(err), 64'd0);
        tick();
        chk("timeout_err", 64'(err), 64'd1);
        chk("timeout_ifu_req", 64'(ifu_req), 64'd0);
        chk("timeout_pc", pc, RPC);
        chk("timeout_cycle_cnt", cycle_cnt, 64'd255);
        ifu_ack = 1'b1;
        tick();
        chk("timeout_sticky", 64'(err), 64'd1);
        chk("timeout_inst", 64'(inst), 64'd0);
        ifu_ack = 1'b0;
        do_reset();

        // Ack arrives one cycle before the timeout
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 254; i++) tick();
        addr_q.push_back(RPC);
        ifu_ack   = 1'b1;
        ifu_rdata = ADDI;
        tick();
        ifu_ack = 1'b0;
        chk("late_ack_err", 64'(err), 64'd0);
        chk("late_ack_inst_valid", 64'(inst_valid), 64'd1);
        chk("late_ack_inst", 64'(inst), 64'(ADDI));

        chk("scoreboard_drained", 64'(addr_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
